// File: rtl/down_timer_arbiter.sv
// down_timer_arbiter: two-requester round-robin arbiter driving a shared
// down-counter. A granted job loads its length, counts down to zero, pulses
// done for one cycle, then returns to IDLE. All outputs are registered.
module down_timer_arbiter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_done;
  logic [1:0]       w_done_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_win;
  logic             w_win_nxt;

  // Winner selection: a lone request wins outright; on a tie the requester
  // that was not served last goes next.
  function automatic logic pick(input logic [1:0] rq, input logic last_srv);
    if (rq == 2'b11) begin
      return ~last_srv;
    end
    return rq[1];
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return {idx, ~idx};
  endfunction

  // Next-state and next-output decode; every next value defaults to hold.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 2'b00;
    w_last_nxt  = r_last;
    w_win_nxt   = r_win;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt  = 2'b00;
        w_busy_nxt = 1'b0;
        if (req != 2'b00) begin
          w_win_nxt   = pick(req, r_last);
          w_state_nxt = S_RUN;
          w_gnt_nxt   = onehot(w_win_nxt);
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = w_win_nxt ? len1 : len0;
        end
      end
      S_RUN: begin
        // Withdrawal beats completion: a dropped request never gets done.
        if (!req[r_win]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_last_nxt  = r_win;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = onehot(r_win);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Requests are not looked at here, so the done pulse always completes
        // and the following cycle is always IDLE.
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
        w_busy_nxt  = 1'b0;
        w_last_nxt  = r_win;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 as first tie winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 2'b00;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_last  <= w_last_nxt;
      r_win   <= w_win_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign count = r_cnt;
  assign done  = r_done;

endmodule

// File: doc/down_timer_arbiter.md
DOWN_TIMER_ARBITER -- requirements
Module: down_timer_arbiter

Interface
REQ-001 Parameter: CNT_W, default 3, width of the countdown counter and of both length inputs.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 Port: req  input  2  request per requester; req[i] held high until done[i] or withdrawn.
REQ-005 Port: len0  input  CNT_W  countdown length for requester 0; sampled only at grant.
REQ-006 Port: len1  input  CNT_W  countdown length for requester 1; sampled only at grant.
REQ-007 Port: gnt  output  2  one-hot grant; at most one bit high.
REQ-008 Port: busy  output  1  high while a job is in RUN or DONE.
REQ-009 Port: count  output  CNT_W  current value of the shared down-counter.
REQ-010 Port: done  output  2  one-cycle completion pulse to the granted requester.

Function
REQ-011 FSM states: IDLE, RUN, DONE; registered outputs only, no combinational paths from inputs to outputs.
REQ-012 IDLE, req==00: hold; gnt=00, busy=0, done=00, count holds its last value.
REQ-013 IDLE, exactly one req bit high: next edge grants it.
REQ-014 IDLE, req==11: round-robin; winner is the requester not recorded in last-served pointer `last`.
REQ-015 On grant edge: state<=RUN, gnt<=one-hot winner, busy<=1, count<=len of winner.
REQ-016 RUN, count!=0, gnt req still high: count<=count-1 each edge; no wrap below zero ever.
REQ-017 RUN, count==0, gnt req still high: state<=DONE, done[winner]<=1; count stays 0.
REQ-018 DONE: one cycle only; next edge: done<=00, gnt<=00, busy<=0, last<=winner, state<=IDLE.
REQ-019 Latency: done[i] rises len+1 edges after the grant edge; len=0 gives done 1 edge after grant.
REQ-020 Minimum one IDLE cycle between jobs; no back-to-back grant from DONE.
REQ-021 Abort: granted req bit low in RUN -> next edge: state<=IDLE, gnt<=00, busy<=0, count<=0, last<=winner, no done pulse.
REQ-022 Abort and count==0 on the same edge: abort wins; no done pulse.
REQ-023 Abort observed in DONE state is ignored; done pulse still completes.
REQ-024 len0/len1 changes after the grant edge do not affect the running job.
REQ-025 Non-granted req changes during RUN/DONE do not affect state, count or gnt.

Reset
REQ-026 rst low forces immediately, without clock: state=IDLE, gnt=00, busy=0, done=00, count=0, last=1 (requester 0 wins first tie).
REQ-027 rst asserted mid-RUN or in DONE aborts the job; no done pulse is produced.
REQ-028 First grant is possible on the first rising edge after rst deasserts.

Verification
REQ-029 Reset, req=01, len0=3 -> edge1 gnt=01 count=3; edges 2-4 count 2,1,0; edge5 done=01; edge6 gnt=00 busy=0.
REQ-030 Reset, req=11, len0=1, len1=2 -> requester 0 granted first, done=01 at grant+2; after one IDLE cycle gnt=10, done=10 at grant+3.
REQ-031 req=10, len1=0 -> gnt=10 count=0, done=10 exactly one edge after grant.
REQ-032 req=01, len0=5, drop req[0] when count=3 -> next edge gnt=00 busy=0 count=0, done stays 00.
REQ-033 req=01, len0=7, pull rst low between edges at count=4 -> outputs clear before next clk edge; release -> IDLE, next grant normal.
REQ-034 Two consecutive contended rounds with req=11 held -> grants alternate 01,10,01; gnt never 11.
